// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind uart_rx: captures each completed byte and its framing flag,
// and serves the entries first-word-fall-through with overrun and error accounting.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter bit DROP_ERR   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_done,
  input  logic                  rx_err,
  output logic [7:0]            m_data,
  output logic                  m_err,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  overrun,
  input  logic                  clr_overrun,
  output logic [7:0]            err_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT  = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ZERO  = (DEPTH_LOG2 + 1)'(0);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ZERO  = DEPTH_LOG2'(0);

  logic [8:0]            mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2:0]   count_r;
  logic                  done_q_r;
  logic                  overrun_r;
  logic [7:0]            err_cnt_r;

  logic event_s;
  logic push_req_s;
  logic empty_s;
  logic full_s;
  logic pop_s;
  logic push_s;
  logic drop_s;

  // Capture event, push/pop qualification and the overflow decision
  always_comb begin
    event_s    = rx_done & ~done_q_r;
    push_req_s = event_s & ~(DROP_ERR & rx_err);
    empty_s    = (count_r == CNT_ZERO);
    full_s     = (count_r == FULL_CNT);
    pop_s      = ~empty_s & m_ready;
    // A full FIFO still accepts a byte when the head leaves in the same cycle
    push_s     = push_req_s & (~full_s | pop_s);
    drop_s     = push_req_s & full_s & ~pop_s;
  end

  // Pointers, occupancy, edge detector and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q_r  <= 1'b1;
      wr_ptr_r  <= PTR_ZERO;
      rd_ptr_r  <= PTR_ZERO;
      count_r   <= CNT_ZERO;
      overrun_r <= 1'b0;
      err_cnt_r <= 8'd0;
    end else begin
      done_q_r <= rx_done;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
      if (drop_s) begin
        overrun_r <= 1'b1;
      end else if (clr_overrun) begin
        overrun_r <= 1'b0;
      end
      if (event_s && rx_err && (err_cnt_r != 8'hFF)) begin
        err_cnt_r <= err_cnt_r + 8'd1;
      end
    end
  end

  // Entry storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (!rst && push_s) begin
      mem_r[wr_ptr_r] <= {rx_err, rx_data};
    end
  end

  assign m_data  = mem_r[rd_ptr_r][7:0];
  assign m_err   = mem_r[rd_ptr_r][8];
  assign m_valid = ~empty_s;
  assign count   = count_r;
  assign full    = full_s;
  assign overrun = overrun_r;
  assign err_cnt = err_cnt_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: vector table, directed corner sequences and a random run,
// with one instance per DROP_ERR setting checked against a queue-based model.
module tb_uart_rx_fifo;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_err;
  logic       m_ready;
  logic       clr_overrun;

  logic [7:0] md [2];
  logic       me [2];
  logic       mv [2];
  logic [4:0] cnt [2];
  logic       fl [2];
  logic       ov [2];
  logic [7:0] ec [2];

  int tests = 0;
  int fails = 0;

  // model state
  logic [8:0] mq [2][$];
  logic       mov [2];
  int         mec [2];
  logic       mprev;

  typedef struct {
    logic       done;
    logic [7:0] data;
    logic       ready;
    logic [4:0] exp_cnt;
    logic       exp_valid;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tbl [11];

  uart_rx_fifo #(.DEPTH_LOG2(4), .DROP_ERR(1'b0)) dut0 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done), .rx_err(rx_err),
    .m_data(md[0]), .m_err(me[0]), .m_valid(mv[0]), .m_ready(m_ready),
    .count(cnt[0]), .full(fl[0]), .overrun(ov[0]), .clr_overrun(clr_overrun),
    .err_cnt(ec[0])
  );

  uart_rx_fifo #(.DEPTH_LOG2(4), .DROP_ERR(1'b1)) dut1 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done), .rx_err(rx_err),
    .m_data(md[1]), .m_err(me[1]), .m_valid(mv[1]), .m_ready(m_ready),
    .count(cnt[1]), .full(fl[1]), .overrun(ov[1]), .clr_overrun(clr_overrun),
    .err_cnt(ec[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference behaviour from the rules: one event per rising done, pop before push,
  // a push is lost only when the FIFO is full and nothing leaves that cycle.
  task automatic model_update();
    logic ev;
    logic pop;
    logic push_req;
    logic drop;
    ev = rx_done && !mprev;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mq[k].delete();
        mov[k] = 1'b0;
        mec[k] = 0;
      end else begin
        pop = (mq[k].size() != 0) && m_ready;
        if (pop) void'(mq[k].pop_front());
        push_req = ev && !((k == 1) && rx_err);
        if (ev && rx_err && mec[k] < 255) mec[k]++;
        drop = 1'b0;
        if (push_req) begin
          if (mq[k].size() < 16) mq[k].push_back({rx_err, rx_data});
          else drop = 1'b1;
        end
        if (drop) mov[k] = 1'b1;
        else if (clr_overrun) mov[k] = 1'b0;
      end
    end
    mprev = rst ? 1'b1 : rx_done;
  endtask

  task automatic check_model();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("m%0d_count", k), int'(cnt[k]), mq[k].size());
      check($sformatf("m%0d_valid", k), int'(mv[k]), int'(mq[k].size() != 0));
      check($sformatf("m%0d_full", k), int'(fl[k]), int'(mq[k].size() == 16));
      check($sformatf("m%0d_overrun", k), int'(ov[k]), int'(mov[k]));
      check($sformatf("m%0d_err_cnt", k), int'(ec[k]), mec[k]);
      if (mq[k].size() != 0) begin
        check($sformatf("m%0d_data", k), int'(md[k]), int'(mq[k][0][7:0]));
        check($sformatf("m%0d_err", k), int'(me[k]), int'(mq[k][0][8]));
      end
    end
  endtask

  task automatic step(input logic r, input logic d, input logic [7:0] dat,
                      input logic e, input logic rdy, input logic clr);
    rst = r; rx_done = d; rx_data = dat; rx_err = e; m_ready = rdy; clr_overrun = clr;
    @(posedge clk);
    model_update();
    #1;
    check_model();
  endtask

  task automatic send(input logic [7:0] b, input logic e, input logic rdy);
    step(1'b0, 1'b1, b, e, rdy, 1'b0);
    step(1'b0, 1'b0, b, e, rdy, 1'b0);
  endtask

  logic [7:0] exp_seq [16];
  logic       hi;
  int         len;
  logic [7:0] rd;
  logic       re;

  initial begin
    tbl[0]  = '{1'b1, 8'h00, 1'b0, 5'd0, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 8'h00, 1'b0, 5'd0, 1'b0, 8'h00};
    tbl[2]  = '{1'b1, 8'h00, 1'b0, 5'd0, 1'b0, 8'h00};
    tbl[3]  = '{1'b1, 8'h00, 1'b0, 5'd0, 1'b0, 8'h00};
    tbl[4]  = '{1'b1, 8'h00, 1'b0, 5'd0, 1'b0, 8'h00};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 8'h00};
    tbl[6]  = '{1'b1, 8'h9C, 1'b0, 5'd1, 1'b1, 8'h9C};
    tbl[7]  = '{1'b1, 8'h9C, 1'b0, 5'd1, 1'b1, 8'h9C};
    tbl[8]  = '{1'b1, 8'h9C, 1'b0, 5'd1, 1'b1, 8'h9C};
    tbl[9]  = '{1'b0, 8'h9C, 1'b0, 5'd1, 1'b1, 8'h9C};
    tbl[10] = '{1'b0, 8'h9C, 1'b1, 5'd0, 1'b0, 8'h00};

    mprev = 1'b1;
    for (int k = 0; k < 2; k++) begin
      mov[k] = 1'b0;
      mec[k] = 0;
    end

    // reset with rx_done held high across release
    step(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    check("reset_count", int'(cnt[0]), 0);
    check("reset_valid", int'(mv[0]), 0);

    for (int i = 0; i < 11; i++) begin
      step(1'b0, tbl[i].done, tbl[i].data, 1'b0, tbl[i].ready, 1'b0);
      check($sformatf("tbl%0d_count", i), int'(cnt[0]), int'(tbl[i].exp_cnt));
      check($sformatf("tbl%0d_valid", i), int'(mv[0]), int'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) begin
        check($sformatf("tbl%0d_data", i), int'(md[0]), int'(tbl[i].exp_data));
        check($sformatf("tbl%0d_err", i), int'(me[0]), 0);
      end
    end

    // fill to 16, then a 17th byte is dropped
    for (int i = 0; i < 16; i++) send(8'(i), 1'b0, 1'b0);
    check("fill_full", int'(fl[0]), 1);
    check("fill_overrun", int'(ov[0]), 0);
    send(8'hAA, 1'b0, 1'b0);
    check("ovf_full", int'(fl[0]), 1);
    check("ovf_overrun", int'(ov[0]), 1);
    check("ovf_count", int'(cnt[0]), 16);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("clr_overrun", int'(ov[0]), 0);

    // push while full with simultaneous pop
    check("drain_head0", int'(md[0]), 8'h00);
    step(1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
    check("fullpop_count", int'(cnt[0]), 16);
    check("fullpop_overrun", int'(ov[0]), 0);
    for (int i = 0; i < 15; i++) exp_seq[i] = 8'(i + 1);
    exp_seq[15] = 8'h55;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain%0d", i), int'(md[0]), int'(exp_seq[i]));
      step(1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 1'b0);
    end
    check("drain_empty", int'(cnt[0]), 0);

    // framing error handling in both DROP_ERR modes
    step(1'b0, 1'b1, 8'h7E, 1'b1, 1'b0, 1'b0);
    check("ferr_merr0", int'(me[0]), 1);
    check("ferr_data0", int'(md[0]), 8'h7E);
    check("ferr_cnt0", int'(ec[0]), 1);
    check("ferr_count1", int'(cnt[1]), 0);
    check("ferr_cnt1", int'(ec[1]), 1);
    step(1'b0, 1'b0, 8'h7E, 1'b1, 1'b1, 1'b0);

    // error counter saturation
    for (int i = 0; i < 300; i++) send(8'(i), 1'b1, 1'b1);
    check("sat_cnt0", int'(ec[0]), 255);
    check("sat_cnt1", int'(ec[1]), 255);

    // reset with entries stored
    for (int i = 0; i < 5; i++) send(8'(i + 8'h30), 1'b0, 1'b0);
    check("pre_rst_count", int'(cnt[0]), 5);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("rst_count", int'(cnt[0]), 0);
    check("rst_valid", int'(mv[0]), 0);
    check("rst_err_cnt", int'(ec[0]), 0);

    // randomized run
    hi = 1'b0; len = 0; rd = 8'h00; re = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (len == 0) begin
        hi = ~hi;
        len = int'($urandom_range(1, 4));
        if (hi) begin
          rd = 8'($urandom);
          re = ($urandom_range(0, 5) == 0);
        end
      end
      len--;
      step(($urandom_range(0, 999) == 0), hi, rd, re,
           (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 31) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
